// File: rtl/calculator_seq.sv
// rtl/calculator_seq.sv - multi-cycle add/sub/mul/div/mod/square calculator; optional CALC_ACCUM_EN adds use_acc
module calculator_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2:0]         func,
  input  logic [WIDTH-1:0]   num1,
  input  logic [WIDTH-1:0]   num2,
`ifdef CALC_ACCUM_EN
  input  logic               use_acc,
`endif
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] F_ADD = 3'd0;
  localparam logic [2:0] F_SUB = 3'd1;
  localparam logic [2:0] F_MUL = 3'd2;
  localparam logic [2:0] F_DIV = 3'd3;
  localparam logic [2:0] F_MOD = 3'd4;
  localparam logic [2:0] F_SQR = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDSUB = 2'd1,
    S_ITER   = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  state_t               r_state;
  logic [2:0]           r_func;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_rem;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;
  logic [2*WIDTH-1:0]   r_result;

  logic [WIDTH-1:0]     w_op_a;
  logic                 w_is_iter;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_rem_sh;
  logic [WIDTH:0]       w_rem_sub;
  logic                 w_div_ge;
  logic [WIDTH-1:0]     w_div_rem;
  logic                 w_div_zero;
  logic [2*WIDTH-1:0]   w_final;
  logic                 w_final_err;

  // Operand A source: chained accumulator or the num1 input
`ifdef CALC_ACCUM_EN
  assign w_op_a = use_acc ? r_result[WIDTH-1:0] : num1;
`else
  assign w_op_a = num1;
`endif

  assign w_is_iter = (func == F_MUL) || (func == F_DIV) ||
                     (func == F_MOD) || (func == F_SQR);

  // Shift-add multiplier step, multiplier bits consumed MSB first
  assign w_mul_next = {r_acc[2*WIDTH-2:0], 1'b0} +
                      (r_b[r_cnt] ? {{WIDTH{1'b0}}, r_a} : {(2*WIDTH){1'b0}});

  // Restoring divider step, dividend bits consumed MSB first
  assign w_rem_sh  = {r_rem, r_a[r_cnt]};
  assign w_rem_sub = w_rem_sh - {1'b0, r_b};
  assign w_div_ge  = (w_rem_sh >= {1'b0, r_b});
  assign w_div_rem = w_div_ge ? w_rem_sub[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

  assign w_div_zero = (r_b == '0);

  // Final result/err selection; divide-by-zero values are forced, not taken from the divider
  always_comb begin
    w_final     = r_acc;
    w_final_err = 1'b0;
    case (r_func)
      F_DIV: begin
        w_final     = w_div_zero ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}}
                                 : {{WIDTH{1'b0}}, r_acc[WIDTH-1:0]};
        w_final_err = w_div_zero;
      end
      F_MOD: begin
        w_final     = w_div_zero ? {{WIDTH{1'b0}}, r_a}
                                 : {{WIDTH{1'b0}}, r_rem};
        w_final_err = w_div_zero;
      end
      F_ADD, F_SUB, F_MUL, F_SQR: begin
        w_final     = r_acc;
        w_final_err = 1'b0;
      end
      default: begin
        w_final     = '0;
        w_final_err = 1'b1;
      end
    endcase
  end

  // Control FSM with registered busy/done/err/result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_func   <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_func  <= func;
            r_a     <= (func == F_SQR) ? num2 : w_op_a;
            r_b     <= num2;
            r_acc   <= '0;
            r_rem   <= '0;
            r_cnt   <= CW'(WIDTH - 1);
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_state <= w_is_iter ? S_ITER : S_ADDSUB;
          end
        end
        S_ADDSUB: begin
          case (r_func)
            F_ADD:   r_acc <= {{WIDTH{1'b0}}, r_a} + {{WIDTH{1'b0}}, r_b};
            F_SUB:   r_acc <= {{WIDTH{1'b0}}, r_a} - {{WIDTH{1'b0}}, r_b};
            default: r_acc <= '0;
          endcase
          r_state <= S_FIN;
        end
        S_ITER: begin
          if ((r_func == F_MUL) || (r_func == F_SQR)) begin
            r_acc <= w_mul_next;
          end else begin
            r_rem <= w_div_rem;
            r_acc <= {r_acc[2*WIDTH-2:0], w_div_ge};
          end
          if (r_cnt == '0) begin
            r_state <= S_FIN;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIN: begin
          r_result <= w_final;
          r_err    <= w_final_err;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign err    = r_err;
  assign result = r_result;

endmodule
